exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Multi-cycle sequencer placed between the control unit and DatapathUnit.
- Gates the PC update, register write and data/IO enables so that IO accesses can stall the core on a ready handshake.
- Halts the core on EBREAK, on an illegal opcode, or on an IO timeout.
- Maintains a retired-instruction counter.
- The datapath gains a pc_write_en input; pc_current updates only when it is 1.

Parameters:
- IO_TIMEOUT, 255: maximum IO_WAIT cycles before a timeout halt (1..2^TO_W-1).
- TO_W, 8: width of the wait counter.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the datapath.
- funct3  in  3  instr[14:12] from the datapath.
- cu_data_read_en  in  1  load request from the control unit.
- cu_data_write_en  in  1  store request from the control unit.
- cu_reg_write_en  in  1  register write request from the control unit.
- is_io  in  1  address decoder flag: the current data address is IO.
- io_ready  in  1  IO device has completed the access.
- pc_write_en  out  1  allow pc_current <= pc_next.
- data_read_en  out  1  gated read enable to the datapath.
- data_write_en  out  1  gated write enable to the datapath.
- reg_write_en  out  1  gated register write enable to the datapath.
- io_req  out  1  one-cycle pulse at the start of an IO access.
- halted  out  1  core is stopped.
- halt_cause  out  2  0 none, 1 EBREAK, 2 illegal opcode, 3 IO timeout.
- instret  out  INSTRET_W  count of retired instructions.

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on reset_n. There is one clock domain.
- Reset values:
  - state = BOOT.
  - All enables = 0; io_req = 0; halted = 0; halt_cause = 0.
  - instret = 0; wait_cnt = 0.
  - Reset asserted mid-IO_WAIT or during HALT aborts immediately to these values.
- The state register is 2 bits with states BOOT, EXEC, IO_WAIT, HALT. Outputs are Moore/Mealy combinational from the state and inputs, except instret, wait_cnt and halt_cause, which are registered.
- BOOT:
  - All enables are 0.
  - Moves to EXEC after exactly 1 cycle, giving instruction memory one settle cycle after reset.
- EXEC, decode priority:
  1. opcode == 1110011 with funct3 == 000 (SYSTEM/EBREAK): all enables 0, go to HALT, halt_cause = 1.
  2. opcode not in LEGAL_OPCODES: all enables 0, go to HALT, halt_cause = 2.
  3. (cu_data_read_en or cu_data_write_en) and is_io:
     - Drive data_read_en and data_write_en = the cu values.
     - Assert io_req = 1 for this cycle only.
     - pc_write_en = 0, reg_write_en = 0.
     - Go to IO_WAIT with wait_cnt = 0.
  4. Otherwise (single-cycle instruction):
     - Enables pass through from the cu inputs.
     - pc_write_en = 1; instret increments; stay in EXEC.
- IO_WAIT:
  - data_read_en and data_write_en hold the values latched in EXEC, because the datapath inputs are stable while the PC is frozen. io_req = 0.
  - If io_ready = 1: pc_write_en = 1, reg_write_en = cu_reg_write_en (load data written that cycle), instret increments, go to EXEC.
  - Else if wait_cnt == IO_TIMEOUT-1: all enables 0, go to HALT, halt_cause = 3.
  - Else wait_cnt increments.
  - When io_ready coincides with the timeout cycle, io_ready wins and the instruction completes.
  - io_ready is ignored outside IO_WAIT, so the minimum IO access is 2 cycles.
- HALT:
  - halted = 1; all enables 0; pc_write_en = 0.
  - Remains in HALT until reset_n asserts. halt_cause is held.
- The PC of the halting instruction is not advanced, so the datapath's pc_current identifies the faulting instruction.
- instret wraps modulo 2^INSTRET_W.
- Memory (non-IO) loads and stores complete in a single EXEC cycle.

Decomposition:
- Package exec_seq_pkg holds:
  - the state encodings;
  - halt cause codes;
  - OPC_SYSTEM = 1110011;
  - LEGAL_OPCODES:
    - current encodings: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0110111, 0010111;
    - legacy encodings: 0000000, 0000100, 0101100, 0110000, 0110100, 0111000.
- One sub-module, opcode_legal_check: combinational, takes opcode and outputs legal. It is reused by the future trap unit.
- The FSM, wait counter and instret counter stay in exec_sequencer.

Test Plan:
1. Reset, then a stream of three ADDI (0010011): BOOT lasts 1 cycle, then pc_write_en = 1 for 3 consecutive cycles, instret = 3, io_req never asserted.
2. IO load (cu_data_read_en = 1, is_io = 1), io_ready after 4 cycles: io_req pulses once, pc_write_en = 0 for 4 IO_WAIT cycles then 1 for one cycle with reg_write_en = 1, data_read_en held throughout, instret += 1.
3. IO store, io_ready never asserted, IO_TIMEOUT = 8: after 8 IO_WAIT cycles halted = 1, halt_cause = 3, pc_write_en stays 0 indefinitely.
4. io_ready = 1 exactly on the timeout cycle: the instruction completes, state returns to EXEC, halted = 0.
5. opcode 1110011 with funct3 = 000 → halted = 1, halt_cause = 1; opcode 1111111 after reset → halted = 1, halt_cause = 2; instret unchanged in both cases.
6. Pulse reset_n low mid-IO_WAIT (asynchronous, between clock edges): all outputs go to 0 immediately, instret = 0; after release, BOOT then EXEC resume normally.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// Shared definitions for the execution sequencer and the opcode legality check:
// state encodings, halt cause codes and the table of accepted major opcodes.
package exec_seq_pkg;

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_EXEC    = 2'd1,
      ST_IO_WAIT = 2'd2,
      ST_HALT    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      HC_NONE       = 2'd0,
      HC_EBREAK     = 2'd1,
      HC_ILLEGAL    = 2'd2,
      HC_IO_TIMEOUT = 2'd3
   } halt_cause_e;

   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam int N_LEGAL = 15;

   // Current RV32I encodings first, then the legacy encodings still decoded.
   localparam logic [6:0] LEGAL_OPCODES [N_LEGAL] = '{
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111,
      7'b0000000, 7'b0000100, 7'b0101100, 7'b0110000, 7'b0110100,
      7'b0111000
   };

endpackage

// File: rtl/opcode_legal_check.sv
// Combinational opcode legality check, shared with the trap unit.
// Ports:
//   opcode : instr[6:0]
//   legal  : 1 when opcode is one of LEGAL_OPCODES
module opcode_legal_check
   import exec_seq_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       legal
);

   always_comb begin
      legal = 1'b0;
      for (int i = 0; i < N_LEGAL; i++) begin
         if (opcode == LEGAL_OPCODES[i]) legal = 1'b1;
      end
   end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer between the control unit and the datapath. Gates PC
// update, register write and data enables so IO accesses can stall the core on
// io_ready, halts on EBREAK / illegal opcode / IO timeout, and counts retired
// instructions.
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   opcode, funct3               : instruction fields from the datapath
//   cu_data_read_en/_write_en    : data access requests from the control unit
//   cu_reg_write_en              : register write request from the control unit
//   is_io, io_ready              : IO address flag and IO completion handshake
//   pc_write_en                  : allow pc_current <= pc_next
//   data_read_en/_write_en       : gated data enables
//   reg_write_en                 : gated register write
//   io_req                       : one-cycle pulse at IO access start
//   halted, halt_cause           : core stopped, and why
//   instret                      : retired-instruction count
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_BOOT    | one settle cycle for instruction memory after reset
// ST_EXEC    | decode / execute single-cycle instructions, launch IO
// ST_IO_WAIT | PC frozen, data enables held until io_ready or timeout
// ST_HALT    | core stopped until reset, halt_cause held
module exec_sequencer
   import exec_seq_pkg::*;
#(
   parameter int IO_TIMEOUT = 255,
   parameter int TO_W       = 8,
   parameter int INSTRET_W  = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 cu_data_read_en,
   input  logic                 cu_data_write_en,
   input  logic                 cu_reg_write_en,
   input  logic                 is_io,
   input  logic                 io_ready,
   output logic                 pc_write_en,
   output logic                 data_read_en,
   output logic                 data_write_en,
   output logic                 reg_write_en,
   output logic                 io_req,
   output logic                 halted,
   output logic [1:0]           halt_cause,
   output logic [INSTRET_W-1:0] instret
);

   state_e                 state_q, state_d;
   halt_cause_e            halt_cause_q, halt_cause_d;
   logic [TO_W-1:0]        wait_cnt_q, wait_cnt_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;
   logic                   io_rd_q, io_rd_d;
   logic                   io_wr_q, io_wr_d;
   logic                   opc_legal;

   opcode_legal_check u_legal (
      .opcode (opcode),
      .legal  (opc_legal)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_BOOT;
         halt_cause_q <= HC_NONE;
         wait_cnt_q   <= '0;
         instret_q    <= '0;
         io_rd_q      <= 1'b0;
         io_wr_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         halt_cause_q <= halt_cause_d;
         wait_cnt_q   <= wait_cnt_d;
         instret_q    <= instret_d;
         io_rd_q      <= io_rd_d;
         io_wr_q      <= io_wr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      halt_cause_d  = halt_cause_q;
      wait_cnt_d    = wait_cnt_q;
      instret_d     = instret_q;
      io_rd_d       = io_rd_q;
      io_wr_d       = io_wr_q;
      pc_write_en   = 1'b0;
      data_read_en  = 1'b0;
      data_write_en = 1'b0;
      reg_write_en  = 1'b0;
      io_req        = 1'b0;
      halted        = 1'b0;

      case (state_q)
         ST_BOOT: state_d = ST_EXEC;

         ST_EXEC: begin
            if (opcode == OPC_SYSTEM && funct3 == 3'b000) begin
               state_d      = ST_HALT;
               halt_cause_d = HC_EBREAK;
            end else if (!opc_legal) begin
               state_d      = ST_HALT;
               halt_cause_d = HC_ILLEGAL;
            end else if ((cu_data_read_en || cu_data_write_en) && is_io) begin
               data_read_en  = cu_data_read_en;
               data_write_en = cu_data_write_en;
               io_req        = 1'b1;
               io_rd_d       = cu_data_read_en;
               io_wr_d       = cu_data_write_en;
               wait_cnt_d    = '0;
               state_d       = ST_IO_WAIT;
            end else begin
               data_read_en  = cu_data_read_en;
               data_write_en = cu_data_write_en;
               reg_write_en  = cu_reg_write_en;
               pc_write_en   = 1'b1;
               instret_d     = instret_q + INSTRET_W'(1);
            end
         end

         ST_IO_WAIT: begin
            // io_ready takes priority over a timeout in the same cycle.
            if (io_ready) begin
               pc_write_en   = 1'b1;
               data_read_en  = io_rd_q;
               data_write_en = io_wr_q;
               reg_write_en  = cu_reg_write_en;
               instret_d     = instret_q + INSTRET_W'(1);
               state_d       = ST_EXEC;
            end else if (wait_cnt_q == TO_W'(IO_TIMEOUT - 1)) begin
               state_d      = ST_HALT;
               halt_cause_d = HC_IO_TIMEOUT;
            end else begin
               data_read_en  = io_rd_q;
               data_write_en = io_wr_q;
               wait_cnt_d    = wait_cnt_q + TO_W'(1);
            end
         end

         ST_HALT: halted = 1'b1;

         default: state_d = ST_BOOT;
      endcase
   end

   assign halt_cause = halt_cause_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [6:0]  opcode = 7'b0010011;
   logic [2:0]  funct3 = 3'b000;
   logic        cu_rd = 1'b0, cu_wr = 1'b0, cu_reg = 1'b0, is_io = 1'b0, io_ready = 1'b0;
   logic        pc_write_en, data_read_en, data_write_en, reg_write_en, io_req, halted;
   logic [1:0]  halt_cause;
   logic [31:0] instret;

   int checks = 0;
   int failures = 0;
   int ioreq_cnt = 0;
   int pc_cnt = 0;

   // Reference model: abstract view of the core's progress.
   bit          m_boot, m_halt, m_inio, m_rd, m_wr;
   int          m_cause, m_wait;
   logic [31:0] m_instret;

   logic [6:0] legal_list [15] = '{
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111,
      7'b0000000, 7'b0000100, 7'b0101100, 7'b0110000, 7'b0110100,
      7'b0111000
   };

   exec_sequencer #(.IO_TIMEOUT(TO), .TO_W(8), .INSTRET_W(32)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .opcode           (opcode),
      .funct3           (funct3),
      .cu_data_read_en  (cu_rd),
      .cu_data_write_en (cu_wr),
      .cu_reg_write_en  (cu_reg),
      .is_io            (is_io),
      .io_ready         (io_ready),
      .pc_write_en      (pc_write_en),
      .data_read_en     (data_read_en),
      .data_write_en    (data_write_en),
      .reg_write_en     (reg_write_en),
      .io_req           (io_req),
      .halted           (halted),
      .halt_cause       (halt_cause),
      .instret          (instret)
   );

   always #5 clk = ~clk;

   function automatic bit is_legal(logic [6:0] o);
      foreach (legal_list[i]) if (legal_list[i] == o) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(logic [6:0] op, logic [2:0] f3, bit rd, bit wr, bit rg, bit io, bit rdy);
      opcode = op; funct3 = f3; cu_rd = rd; cu_wr = wr; cu_reg = rg; is_io = io; io_ready = rdy;
   endtask

   task automatic model_reset();
      m_boot = 1; m_halt = 0; m_inio = 0; m_rd = 0; m_wr = 0;
      m_cause = 0; m_wait = 0; m_instret = '0;
   endtask

   // Async reset asserted between edges; starts and ends at posedge+1.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_pc", pc_write_en, 0);
      chk("rst_rd", data_read_en, 0);
      chk("rst_wr", data_write_en, 0);
      chk("rst_reg", reg_write_en, 0);
      chk("rst_ioreq", io_req, 0);
      chk("rst_halted", halted, 0);
      chk("rst_cause", halt_cause, 0);
      chk("rst_instret", instret, 0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // One clock cycle with the current inputs; starts and ends at posedge+1.
   task automatic cycle();
      bit e_pc, e_rd, e_wr, e_reg, e_req;
      bit n_boot, n_halt, n_inio, n_rd, n_wr;
      int n_cause, n_wait;
      logic [31:0] n_instret;
      @(negedge clk);
      e_pc = 0; e_rd = 0; e_wr = 0; e_reg = 0; e_req = 0;
      n_boot = m_boot; n_halt = m_halt; n_inio = m_inio; n_rd = m_rd; n_wr = m_wr;
      n_cause = m_cause; n_wait = m_wait; n_instret = m_instret;
      if (m_boot) begin
         n_boot = 0;
      end else if (m_halt) begin
         // stopped
      end else if (m_inio) begin
         if (io_ready) begin
            e_pc = 1; e_rd = m_rd; e_wr = m_wr; e_reg = cu_reg;
            n_instret = m_instret + 1; n_inio = 0;
         end else if (m_wait == TO - 1) begin
            n_halt = 1; n_cause = 3; n_inio = 0;
         end else begin
            e_rd = m_rd; e_wr = m_wr; n_wait = m_wait + 1;
         end
      end else if (opcode == 7'b1110011 && funct3 == 3'b000) begin
         n_halt = 1; n_cause = 1;
      end else if (!is_legal(opcode)) begin
         n_halt = 1; n_cause = 2;
      end else if ((cu_rd || cu_wr) && is_io) begin
         e_rd = cu_rd; e_wr = cu_wr; e_req = 1;
         n_inio = 1; n_rd = cu_rd; n_wr = cu_wr; n_wait = 0;
      end else begin
         e_rd = cu_rd; e_wr = cu_wr; e_reg = cu_reg; e_pc = 1;
         n_instret = m_instret + 1;
      end
      chk("pc_write_en", pc_write_en, e_pc);
      chk("data_read_en", data_read_en, e_rd);
      chk("data_write_en", data_write_en, e_wr);
      chk("reg_write_en", reg_write_en, e_reg);
      chk("io_req", io_req, e_req);
      chk("halted", halted, m_halt);
      chk("halt_cause", halt_cause, m_cause);
      chk("instret", instret, m_instret);
      ioreq_cnt += int'(io_req);
      pc_cnt += int'(pc_write_en);
      @(posedge clk);
      m_boot = n_boot; m_halt = n_halt; m_inio = n_inio; m_rd = n_rd; m_wr = n_wr;
      m_cause = n_cause; m_wait = n_wait; m_instret = n_instret;
      #1;
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // 1: boot then three ADDI
      set_in(7'b0010011, 3'b000, 0, 0, 1, 0, 0);
      ioreq_cnt = 0; pc_cnt = 0;
      repeat (4) cycle();
      chk("t1_pc_cycles", pc_cnt, 3);
      chk("t1_instret", instret, 3);
      chk("t1_no_ioreq", ioreq_cnt, 0);

      // 2: IO load, ready after 4 wait cycles
      ioreq_cnt = 0; pc_cnt = 0;
      set_in(7'b0000011, 3'b010, 1, 0, 1, 1, 0);
      repeat (5) cycle();
      chk("t2_pc_frozen", pc_cnt, 0);
      io_ready = 1;
      #1 chk("t2_rd_held", data_read_en, 1);
      chk("t2_reg_we", reg_write_en, 1);
      cycle();
      chk("t2_ioreq_once", ioreq_cnt, 1);
      chk("t2_instret", instret, 4);

      // 3: IO store never ready -> timeout halt after TO wait cycles
      set_in(7'b0100011, 3'b010, 0, 1, 0, 1, 0);
      repeat (1 + TO) cycle();
      chk("t3_halted", halted, 1);
      chk("t3_cause", halt_cause, 3);
      pc_cnt = 0;
      io_ready = 1;
      repeat (5) cycle();
      chk("t3_pc_stays0", pc_cnt, 0);

      // 4: io_ready lands exactly on the timeout cycle
      do_reset();
      set_in(7'b0100011, 3'b010, 0, 1, 0, 1, 0);
      repeat (2 + TO - 1) cycle();
      io_ready = 1;
      cycle();
      set_in(7'b0010011, 3'b000, 0, 0, 1, 0, 0);
      cycle();
      chk("t4_not_halted", halted, 0);
      chk("t4_instret", instret, 2);

      // 5: EBREAK, then illegal opcode
      do_reset();
      set_in(7'b1110011, 3'b000, 0, 0, 1, 0, 0);
      repeat (3) cycle();
      chk("t5_ebreak_cause", halt_cause, 1);
      chk("t5_ebreak_instret", instret, 0);
      do_reset();
      set_in(7'b1111111, 3'b000, 0, 0, 1, 0, 0);
      repeat (3) cycle();
      chk("t5_illegal_cause", halt_cause, 2);
      chk("t5_illegal_halted", halted, 1);

      // 6: async reset mid IO_WAIT
      do_reset();
      set_in(7'b0010011, 3'b000, 0, 0, 1, 0, 0);
      repeat (3) cycle();
      set_in(7'b0000011, 3'b010, 1, 0, 1, 1, 0);
      repeat (3) cycle();
      do_reset();
      set_in(7'b0010011, 3'b000, 0, 0, 1, 0, 0);
      repeat (3) cycle();
      chk("t6_resume_instret", instret, 2);

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         int r;
         logic [6:0] op;
         logic [2:0] f3;
         r = int'($urandom_range(0, 99));
         f3 = 3'($urandom_range(0, 7));
         if (r < 92) op = legal_list[$urandom_range(0, 14)];
         else if (r < 96) begin
            op = 7'b1110011;
            if ($urandom_range(0, 1) == 0) f3 = 3'b000;
         end else op = 7'($urandom);
         set_in(op, f3, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30);
         if (m_halt && $urandom_range(0, 3) == 0) do_reset();
         else cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
